// File: rtl/dmem_pkg.sv
// Shared funct3 decode and byte-lane helpers for the data-memory load/store unit.
package dmem_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_D  = 3'b011,
    F3_BU = 3'b100,
    F3_HU = 3'b101,
    F3_WU = 3'b110
  } funct3_e;

  typedef struct packed {
    logic       legal;
    logic       isUnsigned;
    logic [1:0] sizeLog2;
  } accessDecode_t;

  // Stores never take the unsigned codes; double-word forms exist only on RV64.
  function automatic accessDecode_t sizeDecode(input logic [2:0] funct3,
                                               input logic       isStore,
                                               input logic       rv64);
    accessDecode_t d;
    d = '0;
    case (funct3)
      F3_B:    begin d.legal = 1'b1;             d.sizeLog2 = 2'd0; end
      F3_H:    begin d.legal = 1'b1;             d.sizeLog2 = 2'd1; end
      F3_W:    begin d.legal = 1'b1;             d.sizeLog2 = 2'd2; end
      F3_D:    begin d.legal = rv64;             d.sizeLog2 = 2'd3; end
      F3_BU:   begin d.legal = !isStore;         d.sizeLog2 = 2'd0; d.isUnsigned = 1'b1; end
      F3_HU:   begin d.legal = !isStore;         d.sizeLog2 = 2'd1; d.isUnsigned = 1'b1; end
      F3_WU:   begin d.legal = !isStore && rv64; d.sizeLog2 = 2'd2; d.isUnsigned = 1'b1; end
      default: d = '0;
    endcase
    return d;
  endfunction

  function automatic logic [7:0] byteEnable(input logic [1:0] sizeLog2,
                                            input logic [2:0] offset);
    logic [7:0] mask;
    case (sizeLog2)
      2'd0:    mask = 8'h01;
      2'd1:    mask = 8'h03;
      2'd2:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask << offset;
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response bundle between the MEM stage (master) and the load/store unit (slave).
interface dmem_lsu_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [DM_ADDRESS-1:0] req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [2:0]            req_funct3;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_bank.sv
// Byte-lane RAM: one row per data word, per-byte write enables, registered read port.
module dmem_bank #(
  parameter int LANES = 4,
  parameter int ROW_W = 7
) (
  input  logic               clk,
  input  logic [ROW_W-1:0]   rowAddr_i,
  input  logic [LANES-1:0]   we_i,
  input  logic               re_i,
  input  logic [LANES*8-1:0] wdata_i,
  output logic [LANES*8-1:0] rdata_o
);
  logic [LANES*8-1:0] mem_q [0:(1<<ROW_W)-1];
  logic [LANES*8-1:0] rdata_q;

  // Read data only moves on a load, so a held response keeps its bytes.
  always_ff @(posedge clk) begin
    for (int b = 0; b < LANES; b++) begin
      if (we_i[b]) mem_q[rowAddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
    end
    if (re_i) rdata_q <= mem_q[rowAddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/dmem_lsu.sv
// MEM-stage load/store unit: funct3 decode, alignment check, lane placement,
// load extension and a single-entry response register.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input logic       clk,
  input logic       rst_n,
  dmem_lsu_if.slave bus
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int ROW_W = DM_ADDRESS - OFF_W;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RESP = 1'b1;

  accessDecode_t     dec;
  logic [2:0]        off3;
  logic [2:0]        alignMask;
  logic              reqOk;
  logic              accept;
  logic [NB-1:0]     bankWe;
  logic              bankRe;
  logic [DATA_W-1:0] bankWdata;
  logic [DATA_W-1:0] bankRdata;

  logic [0:0] state_q, state_d;
  logic       respErr_q, respErr_d;
  logic       respLoad_q, respLoad_d;
  logic       respUns_q, respUns_d;
  logic [1:0] respSize_q, respSize_d;
  logic [2:0] respOff_q, respOff_d;

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] lowMask;
  logic [6:0]        nBits;
  logic              signBit;

  assign dec = sizeDecode(bus.req_funct3, bus.req_we, DATA_W == 64);

  always_comb begin
    off3 = '0;
    off3[OFF_W-1:0] = bus.req_addr[OFF_W-1:0];
    case (dec.sizeLog2)
      2'd0:    alignMask = 3'b000;
      2'd1:    alignMask = 3'b001;
      2'd2:    alignMask = 3'b011;
      default: alignMask = 3'b111;
    endcase
  end

  assign reqOk = dec.legal && ((bus.req_addr[2:0] & alignMask) == 3'b000);

  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.req_ready  = !bus.resp_valid || bus.resp_ready;
  assign accept         = bus.req_valid && bus.req_ready;

  // Writes are gated by rst_n so a store presented during reset never lands.
  assign bankWe    = (accept && bus.req_we && reqOk && rst_n) ? NB'(byteEnable(dec.sizeLog2, off3)) : '0;
  assign bankRe    = accept && !bus.req_we && reqOk;
  assign bankWdata = bus.req_wdata << {off3, 3'b000};

  dmem_bank #(
    .LANES (NB),
    .ROW_W (ROW_W)
  ) u_bank (
    .clk       (clk),
    .rowAddr_i (bus.req_addr[DM_ADDRESS-1:OFF_W]),
    .we_i      (bankWe),
    .re_i      (bankRe),
    .wdata_i   (bankWdata),
    .rdata_o   (bankRdata)
  );

  always_comb begin
    state_d    = state_q;
    respErr_d  = respErr_q;
    respLoad_d = respLoad_q;
    respUns_d  = respUns_q;
    respSize_d = respSize_q;
    respOff_d  = respOff_q;
    if (accept) begin
      state_d    = S_RESP;
      respErr_d  = !reqOk;
      respLoad_d = reqOk && !bus.req_we;
      respUns_d  = dec.isUnsigned;
      respSize_d = dec.sizeLog2;
      respOff_d  = off3;
    end else if (bus.resp_ready) begin
      state_d    = S_IDLE;
      respErr_d  = 1'b0;
      respLoad_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      respErr_q  <= 1'b0;
      respLoad_q <= 1'b0;
      respUns_q  <= 1'b0;
      respSize_q <= 2'd0;
      respOff_q  <= 3'd0;
    end else begin
      state_q    <= state_d;
      respErr_q  <= respErr_d;
      respLoad_q <= respLoad_d;
      respUns_q  <= respUns_d;
      respSize_q <= respSize_d;
      respOff_q  <= respOff_d;
    end
  end

  // Extension works on the registered row, so it stays valid for as long as the response is held.
  always_comb begin
    shifted = bankRdata >> {respOff_q, 3'b000};
    nBits   = 7'd8 << respSize_q;
    lowMask = ~({DATA_W{1'b1}} << nBits);
    signBit = 1'b0;
    case (respSize_q)
      2'd0:    signBit = shifted[7];
      2'd1:    signBit = shifted[15];
      2'd2:    signBit = shifted[31];
      default: signBit = shifted[DATA_W-1];
    endcase
  end

  assign bus.resp_rdata = respLoad_q ? ((shifted & lowMask) | ((signBit && !respUns_q) ? ~lowMask : '0)) : '0;
  assign bus.resp_err   = respErr_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: one RV32 and one RV64 instance driven with directed vectors.
module tb_dmem_lsu;
  import dmem_pkg::*;

  typedef struct {
    logic [63:0] data;
    logic        err;
    logic        b2b;
  } exp_t;

  logic clk = 1'b0;
  logic rst32n;
  logic rst64n;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   last32 = 0;
  int   last64 = 0;
  exp_t q32[$];
  exp_t q64[$];

  dmem_lsu_if #(.DM_ADDRESS(9), .DATA_W(32)) bus32 ();
  dmem_lsu_if #(.DM_ADDRESS(9), .DATA_W(64)) bus64 ();

  dmem_lsu #(.DM_ADDRESS(9), .DATA_W(32)) u32 (.clk(clk), .rst_n(rst32n), .bus(bus32));
  dmem_lsu #(.DM_ADDRESS(9), .DATA_W(64)) u64 (.clk(clk), .rst_n(rst64n), .bus(bus64));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input bit use64, input logic we, input logic [8:0] addr,
                               input logic [63:0] wdata, input logic [2:0] f3,
                               input logic [63:0] expData, input logic expErr, input logic b2b);
    exp_t e;
    bit   acc;
    e.data = expData;
    e.err  = expErr;
    e.b2b  = b2b;
    if (use64) begin
      q64.push_back(e);
      bus64.req_valid = 1'b1; bus64.req_we = we; bus64.req_addr = addr;
      bus64.req_wdata = wdata; bus64.req_funct3 = f3;
    end else begin
      q32.push_back(e);
      bus32.req_valid = 1'b1; bus32.req_we = we; bus32.req_addr = addr;
      bus32.req_wdata = wdata[31:0]; bus32.req_funct3 = f3;
    end
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      #1;
      acc = use64 ? bus64.req_ready : bus32.req_ready;
      if (acc) @(posedge clk);
      else     @(negedge clk);
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got no accept, want accept within 50 cycles (use64=%0d addr=0x%0h)", use64, addr);
    end
    @(negedge clk);
    if (use64) bus64.req_valid = 1'b0;
    else       bus32.req_valid = 1'b0;
  endtask

  // Response monitors: pop the scoreboard whenever a response is consumed at the next edge.
  always @(negedge clk) begin : mon32
    exp_t e;
    #1;
    if (bus32.resp_valid && bus32.resp_ready) begin
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL rsp32_unexpected: got response 0x%0h, want none", bus32.resp_rdata);
      end else begin
        e = q32.pop_front();
        checkOutput("rsp32_rdata", 64'(bus32.resp_rdata), e.data);
        checkOutput("rsp32_err", 64'(bus32.resp_err), 64'(e.err));
        if (e.b2b) checkOutput("rsp32_b2b_gap", 64'(cyc - last32), 64'd1);
      end
      last32 = cyc;
    end
  end

  always @(negedge clk) begin : mon64
    exp_t e;
    #1;
    if (bus64.resp_valid && bus64.resp_ready) begin
      if (q64.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL rsp64_unexpected: got response 0x%0h, want none", bus64.resp_rdata);
      end else begin
        e = q64.pop_front();
        checkOutput("rsp64_rdata", bus64.resp_rdata, e.data);
        checkOutput("rsp64_err", 64'(bus64.resp_err), 64'(e.err));
        if (e.b2b) checkOutput("rsp64_b2b_gap", 64'(cyc - last64), 64'd1);
      end
      last64 = cyc;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, want finish before 100000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst32n = 1'b0;
    rst64n = 1'b0;
    bus32.req_valid = 1'b0; bus32.req_we = 1'b0; bus32.req_addr = '0;
    bus32.req_wdata = '0;   bus32.req_funct3 = '0; bus32.resp_ready = 1'b1;
    bus64.req_valid = 1'b0; bus64.req_we = 1'b0; bus64.req_addr = '0;
    bus64.req_wdata = '0;   bus64.req_funct3 = '0; bus64.resp_ready = 1'b1;

    #1;
    checkOutput("rst32_resp_valid", 64'(bus32.resp_valid), 64'd0);
    checkOutput("rst32_resp_rdata", 64'(bus32.resp_rdata), 64'd0);
    checkOutput("rst32_resp_err",   64'(bus32.resp_err),   64'd0);
    checkOutput("rst64_resp_valid", 64'(bus64.resp_valid), 64'd0);
    checkOutput("rst64_resp_rdata", bus64.resp_rdata,      64'd0);
    checkOutput("rst64_resp_err",   64'(bus64.resp_err),   64'd0);
    repeat (2) @(negedge clk);
    rst32n = 1'b1;
    rst64n = 1'b1;
    #1;
    checkOutput("rst32_req_ready", 64'(bus32.req_ready), 64'd1);
    checkOutput("rst64_req_ready", 64'(bus64.req_ready), 64'd1);
    @(negedge clk);

    // RV32 instance: use64, we, addr, wdata, funct3, expected rdata, expected err, back-to-back
    applyStimulus(0, 1, 9'h010, 64'hDEADBEEF, F3_W,  64'h0,        0, 0);
    applyStimulus(0, 0, 9'h010, 64'h0,        F3_W,  64'hDEADBEEF, 0, 0);
    applyStimulus(0, 1, 9'h013, 64'h80,       F3_B,  64'h0,        0, 0);
    applyStimulus(0, 0, 9'h013, 64'h0,        F3_B,  64'hFFFFFF80, 0, 0);
    applyStimulus(0, 0, 9'h013, 64'h0,        F3_BU, 64'h00000080, 0, 0);
    applyStimulus(0, 0, 9'h010, 64'h0,        F3_W,  64'h80ADBEEF, 0, 0);
    applyStimulus(0, 0, 9'h010, 64'h0,        F3_H,  64'hFFFFBEEF, 0, 0);
    applyStimulus(0, 0, 9'h012, 64'h0,        F3_HU, 64'h000080AD, 0, 0);
    applyStimulus(0, 1, 9'h011, 64'h1234,     F3_H,  64'h0,        1, 0);
    applyStimulus(0, 1, 9'h010, 64'hFF,       F3_BU, 64'h0,        1, 0);
    applyStimulus(0, 0, 9'h012, 64'h0,        F3_W,  64'h0,        1, 0);
    applyStimulus(0, 0, 9'h010, 64'h0,        F3_D,  64'h0,        1, 0);
    applyStimulus(0, 0, 9'h010, 64'h0,        F3_W,  64'h80ADBEEF, 0, 0);
    applyStimulus(0, 1, 9'h020, 64'h11223344, F3_W,  64'h0,        0, 0);
    applyStimulus(0, 0, 9'h022, 64'h0,        F3_H,  64'h00001122, 0, 1);

    // Consumer stall: the held LW must stay put and block the next request.
    @(negedge clk);
    bus32.resp_ready = 1'b0;
    applyStimulus(0, 0, 9'h020, 64'h0, F3_W, 64'h11223344, 0, 0);
    fork
      applyStimulus(0, 0, 9'h020, 64'h0, F3_BU, 64'h44, 0, 0);
      begin
        for (int i = 0; i < 3; i++) begin
          #1;
          checkOutput("stall_resp_valid", 64'(bus32.resp_valid), 64'd1);
          checkOutput("stall_resp_rdata", 64'(bus32.resp_rdata), 64'h11223344);
          checkOutput("stall_req_ready",  64'(bus32.req_ready),  64'd0);
          @(negedge clk);
        end
        bus32.resp_ready = 1'b1;
      end
    join
    applyStimulus(0, 0, 9'h021, 64'h0, F3_B, 64'h33, 0, 0);

    // RV64 instance
    applyStimulus(1, 1, 9'h008, 64'h8000_0000_FFFF_0001, F3_D,  64'h0,                   0, 0);
    applyStimulus(1, 0, 9'h00C, 64'h0,                   F3_WU, 64'h0000_0000_8000_0000, 0, 0);
    applyStimulus(1, 0, 9'h00C, 64'h0,                   F3_W,  64'hFFFF_FFFF_8000_0000, 0, 0);
    applyStimulus(1, 0, 9'h008, 64'h0,                   F3_D,  64'h8000_0000_FFFF_0001, 0, 0);
    applyStimulus(1, 0, 9'h00A, 64'h0,                   F3_H,  64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    applyStimulus(1, 0, 9'h00A, 64'h0,                   F3_HU, 64'h0000_0000_0000_FFFF, 0, 0);
    applyStimulus(1, 0, 9'h008, 64'h0,                   F3_B,  64'h1,                   0, 0);
    applyStimulus(1, 0, 9'h00C, 64'h0,                   F3_D,  64'h0,                   1, 0);
    applyStimulus(1, 0, 9'h00E, 64'h0,                   F3_WU, 64'h0,                   1, 0);
    applyStimulus(1, 1, 9'h00C, 64'hCAFEBABE,            F3_W,  64'h0,                   0, 0);
    applyStimulus(1, 1, 9'h008, 64'h1,                   F3_WU, 64'h0,                   1, 0);
    applyStimulus(1, 0, 9'h008, 64'h0,                   F3_D,  64'hCAFE_BABE_FFFF_0001, 0, 0);

    // Reset while a response is held: it vanishes at once and a store seen during reset is dropped.
    @(negedge clk);
    bus64.resp_ready = 1'b0;
    applyStimulus(1, 0, 9'h008, 64'h0, F3_D, 64'hCAFE_BABE_FFFF_0001, 0, 0);
    #2;
    rst64n = 1'b0;
    #1;
    checkOutput("midrst_resp_valid", 64'(bus64.resp_valid), 64'd0);
    checkOutput("midrst_resp_rdata", bus64.resp_rdata,      64'd0);
    checkOutput("midrst_resp_err",   64'(bus64.resp_err),   64'd0);
    checkOutput("midrst_req_ready",  64'(bus64.req_ready),  64'd1);
    void'(q64.pop_back());
    bus64.req_valid = 1'b1; bus64.req_we = 1'b1; bus64.req_addr = 9'h008;
    bus64.req_wdata = 64'hAA; bus64.req_funct3 = F3_B;
    @(negedge clk);
    bus64.req_valid  = 1'b0;
    rst64n           = 1'b1;
    bus64.resp_ready = 1'b1;
    @(negedge clk);
    applyStimulus(1, 0, 9'h008, 64'h0, F3_B, 64'h1, 0, 0);

    repeat (3) @(negedge clk);
    checkOutput("q32_drained", 64'(q32.size()), 64'd0);
    checkOutput("q64_drained", 64'(q64.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
